// File: rtl/vga_fb_pkg.sv
// rtl/vga_fb_pkg.sv - shared types and default geometry for the framebuffer arbiter
package vga_fb_pkg;

    localparam int FB_H_ACTIVE = 640;
    localparam int FB_V_ACTIVE = 480;
    localparam int FB_DEPTH    = FB_H_ACTIVE * FB_V_ACTIVE;
    localparam int FB_ADDR_W   = $clog2(FB_DEPTH);

    typedef logic [23:0] pixel_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_e;

    function automatic logic [7:0] pix_r(input pixel_t p);
        return p[23:16];
    endfunction

    function automatic logic [7:0] pix_g(input pixel_t p);
        return p[15:8];
    endfunction

    function automatic logic [7:0] pix_b(input pixel_t p);
        return p[7:0];
    endfunction

    function automatic pixel_t pix_pack(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        return {r, g, b};
    endfunction

endpackage

// File: rtl/vga_fb_fill_engine.sv
// rtl/vga_fb_fill_engine.sv - screen-clear engine: walks 0..DEPTH-1 writing one colour
module vga_fb_fill_engine
    import vga_fb_pkg::*;
#(
    parameter int DEPTH  = FB_DEPTH,
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [DATA_W-1:0] color_i,
    input  logic              grant_i,
    output logic              req_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    fill_state_e       state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] color_q;
    logic              done_q;

    // Abort suppresses the request so no write issues in the abort cycle.
    assign req_o  = (state_q == FILL) && !abort_i;
    assign addr_o = addr_q;
    assign data_o = color_q;
    assign busy_o = (state_q == FILL);
    assign done_o = done_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            color_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= FILL;
                        addr_q  <= '0;
                        color_q <= color_i;
                    end
                end
                FILL: begin
                    if (abort_i) begin
                        state_q <= IDLE;
                    end else if (grant_i) begin
                        if (addr_q == LAST_ADDR) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - single-port framebuffer arbiter: display read > host write > fill
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int H_ACTIVE = FB_H_ACTIVE,
    parameter int V_ACTIVE = FB_V_ACTIVE,
    parameter int DEPTH    = H_ACTIVE * V_ACTIVE,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int DATA_W   = 24
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              fill_start,
    input  logic              fill_abort,
    input  logic [DATA_W-1:0] fill_color,
    output logic              fill_busy,
    output logic              fill_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    logic              rstn_q;
    logic              rd_p1_q, rd_p2_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_we_q, ram_we_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

    logic              wr_fire;
    logic              fill_req, fill_grant;
    logic [ADDR_W-1:0] fill_addr;
    logic [DATA_W-1:0] fill_data;

    vga_fb_fill_engine #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fill (
        .clk     (clk),
        .rstn    (rstn),
        .start_i (fill_start),
        .abort_i (fill_abort),
        .color_i (fill_color),
        .grant_i (fill_grant),
        .req_o   (fill_req),
        .addr_o  (fill_addr),
        .data_o  (fill_data),
        .busy_o  (fill_busy),
        .done_o  (fill_done)
    );

    // rstn_q keeps wr_ready low until the first edge out of reset.
    assign wr_ready   = rstn_q && !rd_req;
    assign wr_fire    = wr_valid && wr_ready;
    assign fill_grant = fill_req && !rd_req && !wr_fire;

    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        if (rd_req) begin
            ram_addr_d = rd_addr;
        end else if (wr_fire) begin
            ram_addr_d  = wr_addr;
            ram_we_d    = 1'b1;
            ram_wdata_d = wr_data;
        end else if (fill_grant) begin
            ram_addr_d  = fill_addr;
            ram_we_d    = 1'b1;
            ram_wdata_d = fill_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rstn_q      <= 1'b0;
            rd_p1_q     <= 1'b0;
            rd_p2_q     <= 1'b0;
            rd_data_q   <= '0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
        end else begin
            rstn_q      <= 1'b1;
            rd_p1_q     <= rd_req;
            rd_p2_q     <= rd_p1_q;
            rd_data_q   <= rd_p1_q ? ram_rdata : '0;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign rd_valid  = rd_p2_q;
    assign rd_data   = rd_data_q;
    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - directed self-checking bench for vga_fb_arbiter (DEPTH=16, 10-bit addresses)
module tb_vga_fb_arbiter;

    localparam int AW = 10;
    localparam int DW = 24;

    logic          clk;
    logic          rstn;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          fill_start;
    logic          fill_abort;
    logic [DW-1:0] fill_color;
    logic          fill_busy;
    logic          fill_done;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    vga_fb_arbiter #(
        .H_ACTIVE (4),
        .V_ACTIVE (4),
        .DEPTH    (16),
        .ADDR_W   (AW),
        .DATA_W   (DW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .fill_start (fill_start),
        .fill_abort (fill_abort),
        .fill_color (fill_color),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model plus a log of every RAM write and fill_done pulse.
    logic [DW-1:0] mem    [0:1023];
    logic [AW-1:0] wlog_a [0:63];
    logic [DW-1:0] wlog_d [0:63];
    int            wcnt;
    int            done_cnt;
    logic          bd_init;
    logic          log_clr;

    assign ram_rdata = mem[ram_addr];

    always @(posedge clk) begin
        if (bd_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= DW'(i);
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        if (log_clr) begin
            wcnt     <= 0;
            done_cnt <= 0;
        end else begin
            if (ram_we && wcnt < 64) begin
                wlog_a[wcnt] <= ram_addr;
                wlog_d[wcnt] <= ram_wdata;
                wcnt         <= wcnt + 1;
            end
            if (fill_done) done_cnt <= done_cnt + 1;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Number of logged writes carrying 'color' if their addresses run 0,1,2,... in order, else -1.
    function automatic int fill_seq(input logic [DW-1:0] color);
        int k = 0;
        for (int i = 0; i < wcnt; i++) begin
            if (wlog_d[i] == color) begin
                if (int'(wlog_a[i]) != k) return -1;
                k++;
            end
        end
        return k;
    endfunction

    int nbusy;
    int faddr;
    bit hw_done;
    bit host_now;
    bit seen_we;

    initial begin
        rstn = 1'b0; bd_init = 1'b1; log_clr = 1'b1;
        rd_req = 1'b1; rd_addr = '0;
        wr_valid = 1'b1; wr_addr = '0; wr_data = '0;
        fill_start = 1'b1; fill_abort = 1'b0; fill_color = 24'h123456;

        // Reset hold with every request asserted
        repeat (3) tick();
        check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
        check_eq("rst_rd_data", 32'(rd_data), 32'd0);
        check_eq("rst_ram_we", 32'(ram_we), 32'd0);
        check_eq("rst_ram_addr", 32'(ram_addr), 32'd0);
        check_eq("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        check_eq("rst_fill_busy", 32'(fill_busy), 32'd0);
        check_eq("rst_fill_done", 32'(fill_done), 32'd0);
        rd_req = 1'b0;
        #1;
        check_eq("rst_wr_ready", 32'(wr_ready), 32'd0);

        rstn = 1'b1; wr_valid = 1'b0; fill_start = 1'b0; bd_init = 1'b0;
        tick();
        log_clr = 1'b0;
        check_eq("idle_fill_busy", 32'(fill_busy), 32'd0);

        // Read-only stream, mem[a] = a
        seen_we = 1'b0;
        for (int s = 0; s < 12; s++) begin
            rd_req  = (s < 10);
            rd_addr = AW'(s);
            tick();
            if (ram_we) seen_we = 1'b1;
            check_eq($sformatf("rd_valid_%0d", s), 32'(rd_valid), (s >= 1 && s <= 10) ? 32'd1 : 32'd0);
            check_eq($sformatf("rd_data_%0d", s), 32'(rd_data), (s >= 1 && s <= 10) ? 32'(s - 1) : 32'd0);
        end
        check_eq("rd_no_we", 32'(seen_we), 32'd0);

        // Read beats host write for 4 cycles; write lands after rd_req drops
        wr_valid = 1'b1; wr_addr = 10'h100; wr_data = 24'h00FF00;
        for (int s = 0; s < 4; s++) begin
            rd_req = 1'b1; rd_addr = '0;
            #1;
            check_eq($sformatf("prio_wr_ready_%0d", s), 32'(wr_ready), 32'd0);
            tick();
            check_eq($sformatf("prio_ram_we_%0d", s), 32'(ram_we), 32'd0);
        end
        rd_req = 1'b0;
        #1;
        check_eq("prio_wr_ready_free", 32'(wr_ready), 32'd1);
        tick();
        wr_valid = 1'b0;
        check_eq("prio_cmd_we", 32'(ram_we), 32'd1);
        check_eq("prio_cmd_addr", 32'(ram_addr), 32'h100);
        check_eq("prio_cmd_data", 32'(ram_wdata), 32'h00FF00);
        tick();
        rd_req = 1'b1; rd_addr = 10'h100;
        tick();
        rd_req = 1'b0;
        tick();
        check_eq("prio_rb_valid", 32'(rd_valid), 32'd1);
        check_eq("prio_rb_data", 32'(rd_data), 32'h00FF00);

        // Full fill, no other traffic
        bd_init = 1'b1; log_clr = 1'b1;
        tick();
        bd_init = 1'b0; log_clr = 1'b0;
        fill_start = 1'b1; fill_color = 24'h0000FF;
        tick();
        fill_start = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 40; i++) begin
            if (fill_busy) nbusy++;
            tick();
        end
        check_eq("full_busy_cycles", 32'(nbusy), 32'd16);
        check_eq("full_done_count", 32'(done_cnt), 32'd1);
        check_eq("full_write_count", 32'(wcnt), 32'd16);
        check_eq("full_seq", 32'(fill_seq(24'h0000FF)), 32'd16);
        for (int a = 0; a < 16; a++)
            check_eq($sformatf("full_mem_%0d", a), 32'(mem[a]), 32'h0000FF);
        check_eq("full_mem_16", 32'(mem[16]), 32'd16);

        // Fill interleaved with reads every other cycle and one host write at fill_addr 8
        bd_init = 1'b1; log_clr = 1'b1;
        tick();
        bd_init = 1'b0; log_clr = 1'b0;
        fill_start = 1'b1; fill_color = 24'h0000FF;
        tick();
        fill_start = 1'b0;
        faddr = 0; hw_done = 1'b0;
        for (int c = 0; c < 60; c++) begin
            rd_req   = (c % 2 == 0);
            rd_addr  = 10'd20;
            host_now = (c % 2 == 1) && (faddr == 8) && !hw_done;
            wr_valid = host_now;
            wr_addr  = 10'd3;
            wr_data  = 24'hABCDEF;
            if (host_now) hw_done = 1'b1;
            else if (c % 2 == 1 && faddr < 16) faddr++;
            tick();
        end
        rd_req = 1'b0; wr_valid = 1'b0;
        tick();
        check_eq("mix_busy_end", 32'(fill_busy), 32'd0);
        check_eq("mix_done_count", 32'(done_cnt), 32'd1);
        check_eq("mix_write_count", 32'(wcnt), 32'd17);
        check_eq("mix_seq", 32'(fill_seq(24'h0000FF)), 32'd16);
        check_eq("mix_mem_3", 32'(mem[3]), 32'hABCDEF);
        check_eq("mix_mem_2", 32'(mem[2]), 32'h0000FF);
        check_eq("mix_mem_15", 32'(mem[15]), 32'h0000FF);

        // Abort at fill_addr 5, then restart with start+abort together in IDLE
        bd_init = 1'b1; log_clr = 1'b1;
        tick();
        bd_init = 1'b0; log_clr = 1'b0;
        fill_start = 1'b1; fill_color = 24'h0000FF;
        tick();
        fill_start = 1'b0;
        repeat (5) tick();
        fill_abort = 1'b1;
        tick();
        fill_abort = 1'b0;
        check_eq("abort_busy", 32'(fill_busy), 32'd0);
        check_eq("abort_no_we", 32'(ram_we), 32'd0);
        tick();
        check_eq("abort_write_count", 32'(wcnt), 32'd5);
        check_eq("abort_seq", 32'(fill_seq(24'h0000FF)), 32'd5);
        check_eq("abort_done_count", 32'(done_cnt), 32'd0);
        check_eq("abort_mem_4", 32'(mem[4]), 32'h0000FF);
        check_eq("abort_mem_5", 32'(mem[5]), 32'd5);

        fill_start = 1'b1; fill_abort = 1'b1; fill_color = 24'hFF0000; log_clr = 1'b1;
        tick();
        fill_start = 1'b0; fill_abort = 1'b0; log_clr = 1'b0;
        check_eq("restart_busy", 32'(fill_busy), 32'd1);
        repeat (30) tick();
        check_eq("restart_busy_end", 32'(fill_busy), 32'd0);
        check_eq("restart_done_count", 32'(done_cnt), 32'd1);
        check_eq("restart_write_count", 32'(wcnt), 32'd16);
        check_eq("restart_seq", 32'(fill_seq(24'hFF0000)), 32'd16);
        check_eq("restart_mem_0", 32'(mem[0]), 32'hFF0000);
        check_eq("restart_mem_15", 32'(mem[15]), 32'hFF0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
